// File: rtl/sel_arbiter_if.sv
// Request/grant bundle between the requesters and the select arbiter.
interface sel_arbiter_if;
    logic [3:0] req;
    logic       rr_mode;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    // Requester side drives requests, arbiter side drives the grant.
    modport master (
        output req, rr_mode, done,
        input  gnt, sel, busy, timeout
    );

    modport slave (
        input  req, rr_mode, done,
        output gnt, sel, busy, timeout
    );
endinterface

// File: rtl/sel_arbiter.sv
// Four-way arbiter for a shared 2-bit-select resource: fixed priority or
// round-robin, registered one-hot grant, per-grant timeout and a one-cycle
// holdoff between grants.
module sel_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst,
    sel_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    localparam logic [7:0] Limit = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    // Low for the first edge after reset so no grant lands on that edge.
    logic       armed_q;

    logic [1:0] start;
    logic [1:0] idx;
    logic [1:0] win;
    logic       rel;

    // Winner search: scan from the highest offset down so the lowest offset wins.
    always_comb begin
        start = bus.rr_mode ? last_q + 2'd1 : 2'd0;
        idx   = start;
        win   = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (bus.req[idx]) begin
                win = idx;
            end
        end
    end

    assign rel = bus.done || !bus.req[sel_q];

    // Next-state logic for the IDLE/GRANT/HOLDOFF sequence.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && bus.req != 4'b0000) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    last_d  = win;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                // A release in the expiry cycle wins over the timeout.
                if (rel) begin
                    state_d = HOLDOFF;
                    gnt_d   = 4'b0000;
                end else if (cnt_q == Limit) begin
                    state_d   = HOLDOFF;
                    gnt_d     = 4'b0000;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLDOFF: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            last_q    <= 2'b11;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            armed_q   <= 1'b1;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// Self-checking bench for sel_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_sel_arbiter;

    localparam int TO = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sel_arbiter_if bus ();

    sel_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] obs;
    assign obs = {bus.gnt, bus.sel, bus.busy, bus.timeout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the resource, for how long, and whether we
    // are in the cool-down cycle after a grant.
    int m_owner;
    int m_age;
    bit m_cool;
    bit m_armed;
    int m_last;
    int m_sel;
    bit m_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_cool = 0; m_armed = 0;
            m_last = 3; m_sel = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner >= 0) begin
                if (bus.done || !bus.req[m_owner]) begin
                    m_owner = -1; m_cool = 1;
                end else if (m_age + 1 >= TO) begin
                    m_owner = -1; m_cool = 1; m_to = 1;
                end else begin
                    m_age++;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (m_armed && bus.req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = bus.rr_mode ? (m_last + 1 + k) % 4 : k;
                    if (m_owner < 0 && bus.req[i]) m_owner = i;
                end
                m_last = m_owner; m_sel = m_owner; m_age = 0;
            end
            m_armed = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 4'b0000; bus.rr_mode = 1'b0; bus.done = 1'b0;
        tick();
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs, 8'h00);
        end
        rst = 1'b0;
        bus.req = 4'b0001;
        tick();
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL first_edge_no_grant: got %h want %h", obs, 8'h00);
        end
        tick();
        checks++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL second_edge_grant: got %h want %h", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        bus.req = 4'b0000;
        tick();
        tick();
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL reset_back_idle: got %h want %h", obs, 8'h00);
        end
    endtask

    task automatic test_fixed();
        bus.rr_mode = 1'b0; bus.req = 4'b1010;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
                errors++; $display("FAIL fixed_grant[%0d]: got %h want %h", n, obs, {4'b0010, 2'd1, 1'b1, 1'b0});
            end
            bus.done = 1'b1;
            tick();
            checks++;
            if (obs !== {4'b0000, 2'd1, 1'b1, 1'b0}) begin
                errors++; $display("FAIL fixed_holdoff[%0d]: got %h want %h", n, obs, {4'b0000, 2'd1, 1'b1, 1'b0});
            end
            bus.done = 1'b0;
            tick();
            checks++;
            if (obs !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
                errors++; $display("FAIL fixed_idle[%0d]: got %h want %h", n, obs, {4'b0000, 2'd1, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] e;
        pulse_reset();
        bus.rr_mode = 1'b1; bus.req = 4'b1111; bus.done = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            e = {4'(1 << (i % 4)), 2'(i % 4), 1'b1, 1'b0};
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL rr_grant[%0d]: got %h want %h", i, obs, e);
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            tick();
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bus.rr_mode = 1'b0; bus.req = 4'b0100; bus.done = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
            checks++;
            if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
                errors++; $display("FAIL to_grant[%0d]: got %h want %h", k, obs, {4'b0100, 2'd2, 1'b1, 1'b0});
            end
        end
        tick();
        checks++;
        if (obs !== {4'b0000, 2'd2, 1'b1, 1'b1}) begin
            errors++; $display("FAIL to_pulse: got %h want %h", obs, {4'b0000, 2'd2, 1'b1, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
            errors++; $display("FAIL to_idle: got %h want %h", obs, {4'b0000, 2'd2, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL to_regrant: got %h want %h", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_simultaneous();
        bus.rr_mode = 1'b0; bus.req = 4'b0100; bus.done = 1'b0;
        for (int k = 0; k < TO; k++) tick();
        checks++;
        if (obs !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sim_last_grant: got %h want %h", obs, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        bus.done = 1'b1;
        tick();
        checks++;
        if (obs !== {4'b0000, 2'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sim_no_timeout: got %h want %h", obs, {4'b0000, 2'd2, 1'b1, 1'b0});
        end
        bus.done = 1'b0; bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_drop();
        bus.rr_mode = 1'b0; bus.req = 4'b1000; bus.done = 1'b0;
        tick();
        checks++;
        if (obs !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL drop_grant: got %h want %h", obs, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if (obs !== {4'b0000, 2'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL drop_holdoff: got %h want %h", obs, {4'b0000, 2'd3, 1'b1, 1'b0});
        end
        tick();
        tick();
        checks++;
        if (obs !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL drop_no_grant: got %h want %h", obs, {4'b0000, 2'd3, 1'b0, 1'b0});
        end
        // Request pulse that vanishes before the edge must not be latched.
        #1 bus.req = 4'b0001;
        #3 bus.req = 4'b0000;
        tick();
        checks++;
        if (obs !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL glitch_no_grant: got %h want %h", obs, {4'b0000, 2'd3, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_mid_grant();
        bus.rr_mode = 1'b1; bus.req = 4'b1111; bus.done = 1'b0;
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rst_pre_grant: got %h want %h", obs, {4'b0010, 2'd1, 1'b1, 1'b0});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL rst_async_drop: got %h want %h", obs, 8'h00);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL rst_no_holdoff: got %h want %h", obs, 8'h00);
        end
        tick();
        checks++;
        if (obs !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rst_rr_restart: got %h want %h", obs, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        pulse_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.done    = ($urandom_range(0, 5) == 0);
            bus.rr_mode = 1'($urandom_range(0, 1));
            tick();
            e = {(m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000, 2'(m_sel),
                 (m_owner >= 0) || m_cool, m_to};
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", n, obs, e);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_drop();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
